// File: rtl/vec_mac_pipe_if.sv
// Element/result bus of the dot-product MAC. The operand fetch side drives it as
// master; the MAC is the slave.
interface vec_mac_pipe_if #(
  parameter int DATA_W = 8,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 16
);
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic        [BIAS_W-1:0] x;
  logic                     valid_in;
  logic                     flush;
  logic signed [ACC_W-1:0]  f;
  logic                     valid_out;
  logic                     overflow;
  logic                     busy;

  modport master (
    output a, b, x, valid_in, flush,
    input  f, valid_out, overflow, busy
  );

  modport slave (
    input  a, b, x, valid_in, flush,
    output f, valid_out, overflow, busy
  );
endinterface

// File: rtl/vec_mac_pipe.sv
// Pipelined signed multiply-accumulate: one dot product x + sum(a[i]*b[i]) per
// VEC_LEN accepted elements, with optional saturation and a per-vector overflow flag.
module vec_mac_pipe #(
  parameter int DATA_W     = 8,
  parameter int BIAS_W     = 8,
  parameter int ACC_W      = 16,
  parameter int VEC_LEN    = 3,
  parameter int MUL_STAGES = 2,
  parameter int SAT_EN     = 1
) (
  input logic           clk,
  input logic           reset,
  vec_mac_pipe_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     in_v;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic        [BIAS_W-1:0] in_x;
  logic signed [PROD_W-1:0] product;

  logic                     mul_v [MUL_STAGES];
  logic signed [PROD_W-1:0] mul_p [MUL_STAGES];
  logic        [BIAS_W-1:0] mul_x [MUL_STAGES];

  logic                     prod_v;
  logic signed [ACC_W-1:0]  prod_e;
  logic        [BIAS_W-1:0] prod_x;

  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic                     sticky;
  logic                     done_v;
  logic                     done_o;

  logic signed [ACC_W-1:0]  f_q;
  logic                     valid_q;
  logic                     ovf_q;

  logic                     first_elem;
  logic                     last_elem;
  logic signed [ACC_W-1:0]  add_op;
  logic signed [ACC_W-1:0]  add_sum;
  logic                     add_ovf;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     sticky_next;
  logic                     stage_busy;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      in_v <= 1'b0;
    end else begin
      in_v <= bus.valid_in;
      if (bus.valid_in) begin
        in_a <= bus.a;
        in_b <= bus.b;
        in_x <= bus.x;
      end
    end
  end

  assign product = in_a * in_b;

  // The multiplier is a combinational product retimed through MUL_STAGES registers.
  for (genvar s = 0; s < MUL_STAGES; s++) begin : g_mul
    if (s == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
          mul_v[0] <= 1'b0;
        end else begin
          mul_v[0] <= in_v;
          if (in_v) begin
            mul_p[0] <= product;
            mul_x[0] <= in_x;
          end
        end
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
          mul_v[s] <= 1'b0;
        end else begin
          mul_v[s] <= mul_v[s-1];
          if (mul_v[s-1]) begin
            mul_p[s] <= mul_p[s-1];
            mul_x[s] <= mul_x[s-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      prod_v <= 1'b0;
    end else begin
      prod_v <= mul_v[MUL_STAGES-1];
      if (mul_v[MUL_STAGES-1]) begin
        prod_e <= ACC_W'(mul_p[MUL_STAGES-1]);
        prod_x <= mul_x[MUL_STAGES-1];
      end
    end
  end

  // The bias replaces the running sum on element 0, so a new vector needs no bubble.
  always_comb begin
    first_elem  = (cnt == '0);
    last_elem   = (cnt == CNT_W'(VEC_LEN - 1));
    add_op      = first_elem ? {{(ACC_W-BIAS_W){1'b0}}, prod_x} : acc;
    add_sum     = add_op + prod_e;
    add_ovf     = (add_op[ACC_W-1] == prod_e[ACC_W-1]) &&
                  (add_sum[ACC_W-1] != add_op[ACC_W-1]);
    acc_next    = add_sum;
    if ((SAT_EN != 0) && add_ovf) begin
      acc_next = add_op[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    sticky_next = (first_elem ? 1'b0 : sticky) | add_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      done_v <= 1'b0;
      done_o <= 1'b0;
    end else if (bus.flush) begin
      cnt    <= '0;
      sticky <= 1'b0;
      done_v <= 1'b0;
    end else begin
      done_v <= prod_v && last_elem;
      if (prod_v) begin
        acc    <= acc_next;
        done_o <= sticky_next;
        if (last_elem) begin
          cnt    <= '0;
          sticky <= 1'b0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          sticky <= sticky_next;
        end
      end
    end
  end

  // acc still holds the finished sum here even if the next vector's element 0 is landing.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= done_v;
      ovf_q   <= done_v & done_o;
      if (done_v) begin
        f_q <= acc;
      end
    end
  end

  always_comb begin
    stage_busy = in_v | prod_v | done_v | (cnt != '0);
    for (int s = 0; s < MUL_STAGES; s++) begin
      stage_busy = stage_busy | mul_v[s];
    end
  end

  assign bus.f         = f_q;
  assign bus.valid_out = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = stage_busy;
endmodule

// File: tb/tb_vec_mac_pipe.sv
// Directed bench for vec_mac_pipe: three instances (saturating, wrapping, long-pipe
// VEC_LEN=1) share one stimulus stream; results are queued with their cycle stamp.
module tb_vec_mac_pipe;
  typedef struct {
    int f;
    int o;
    int c;
  } res_t;

  logic              clk;
  logic              reset;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic        [7:0] x;
  logic              valid_in;
  logic              flush;
  int                cyc;
  int                checks;
  int                errors;
  res_t              q_sat[$];
  res_t              q_wrap[$];
  res_t              q_long[$];

  vec_mac_pipe_if #(.DATA_W(8), .BIAS_W(8), .ACC_W(16)) bus_sat ();
  vec_mac_pipe_if #(.DATA_W(8), .BIAS_W(8), .ACC_W(16)) bus_wrap ();
  vec_mac_pipe_if #(.DATA_W(8), .BIAS_W(8), .ACC_W(16)) bus_long ();

  assign bus_sat.a         = a;
  assign bus_sat.b         = b;
  assign bus_sat.x         = x;
  assign bus_sat.valid_in  = valid_in;
  assign bus_sat.flush     = flush;
  assign bus_wrap.a        = a;
  assign bus_wrap.b        = b;
  assign bus_wrap.x        = x;
  assign bus_wrap.valid_in = valid_in;
  assign bus_wrap.flush    = flush;
  assign bus_long.a        = a;
  assign bus_long.b        = b;
  assign bus_long.x        = x;
  assign bus_long.valid_in = valid_in;
  assign bus_long.flush    = flush;

  vec_mac_pipe #(.DATA_W(8), .BIAS_W(8), .ACC_W(16), .VEC_LEN(3), .MUL_STAGES(2), .SAT_EN(1))
    dut_sat (.clk(clk), .reset(reset), .bus(bus_sat));
  vec_mac_pipe #(.DATA_W(8), .BIAS_W(8), .ACC_W(16), .VEC_LEN(3), .MUL_STAGES(2), .SAT_EN(0))
    dut_wrap (.clk(clk), .reset(reset), .bus(bus_wrap));
  vec_mac_pipe #(.DATA_W(8), .BIAS_W(8), .ACC_W(16), .VEC_LEN(1), .MUL_STAGES(4), .SAT_EN(1))
    dut_long (.clk(clk), .reset(reset), .bus(bus_long));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mkRes(input int f, input int o, input int c);
    res_t r;
    r.f = f;
    r.o = o;
    r.c = c;
    return r;
  endfunction

  // Outputs are sampled on the falling edge, stamped with the count of rising edges so far.
  always @(negedge clk) begin
    if (bus_sat.valid_out)  q_sat.push_back(mkRes(int'(bus_sat.f), int'(bus_sat.overflow), cyc));
    if (bus_wrap.valid_out) q_wrap.push_back(mkRes(int'(bus_wrap.f), int'(bus_wrap.overflow), cyc));
    if (bus_long.valid_out) q_long.push_back(mkRes(int'(bus_long.f), int'(bus_long.overflow), cyc));
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkResult(input string tag, input res_t q[$], input int idx,
                             input int ef, input int eo, input int ec);
    if (idx < q.size()) begin
      checkOutput({tag, "_f"}, q[idx].f, ef);
      checkOutput({tag, "_ovf"}, q[idx].o, eo);
      checkOutput({tag, "_cyc"}, q[idx].c, ec);
    end else begin
      checkOutput({tag, "_present"}, q.size(), idx + 1);
    end
  endtask

  task automatic applyStimulus(input logic signed [7:0] ta, input logic signed [7:0] tb_v,
                               input logic [7:0] tx, output int samp);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    x        = tx;
    valid_in = 1'b1;
    flush    = 1'b0;
    samp     = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic runBasic(input bit gaps, output int s0, output int s1, output int s2);
    applyStimulus(8'sd2, 8'sd5, 8'd10, s0);
    if (gaps && $urandom_range(0, 1) == 1) idle(1);
    applyStimulus(8'sd3, 8'sd6, 8'd0, s1);
    if (gaps && $urandom_range(0, 1) == 1) idle(1);
    applyStimulus(-8'sd4, 8'sd7, 8'd0, s2);
  endtask

  task automatic clearQ();
    q_sat.delete();
    q_wrap.delete();
    q_long.delete();
  endtask

  initial begin
    int s0, s1, s2, sa, sb, sc, tmp;
    checks   = 0;
    errors   = 0;
    a        = '0;
    b        = '0;
    x        = '0;
    valid_in = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_f", int'(bus_sat.f), 0);
    checkOutput("rst_valid", int'(bus_sat.valid_out), 0);
    checkOutput("rst_ovf", int'(bus_sat.overflow), 0);
    checkOutput("rst_busy", int'(bus_sat.busy), 0);
    checkOutput("rst_busy_long", int'(bus_long.busy), 0);
    reset = 1'b0;

    $display("[TB] basic vector");
    clearQ();
    runBasic(1'b0, s0, s1, s2);
    idle(12);
    checkOutput("basic_count", q_sat.size(), 1);
    checkResult("basic_sat", q_sat, 0, 10, 0, s2 + 5);
    checkResult("basic_wrap", q_wrap, 0, 10, 0, s2 + 5);
    checkOutput("long_count", q_long.size(), 3);
    checkResult("long0", q_long, 0, 20, 0, s0 + 7);
    checkResult("long1", q_long, 1, 18, 0, s1 + 7);
    checkResult("long2", q_long, 2, -28, 0, s2 + 7);
    checkOutput("basic_idle_busy", int'(bus_sat.busy), 0);

    $display("[TB] saturation");
    clearQ();
    repeat (3) applyStimulus(-8'sd128, -8'sd128, 8'd0, tmp);
    idle(10);
    checkResult("sat_pos", q_sat, 0, 32767, 1, tmp + 5);
    checkResult("wrap_pos", q_wrap, 0, -16384, 1, tmp + 5);

    clearQ();
    repeat (3) applyStimulus(-8'sd128, 8'sd127, 8'd0, tmp);
    idle(10);
    checkResult("sat_neg", q_sat, 0, -32768, 1, tmp + 5);
    checkResult("wrap_neg", q_wrap, 0, 16768, 1, tmp + 5);

    $display("[TB] streaming");
    clearQ();
    runBasic(1'b0, s0, s1, sa);
    repeat (3) applyStimulus(8'sd1, 8'sd1, 8'd0, sb);
    idle(1);
    runBasic(1'b1, s0, s1, sc);
    idle(12);
    checkOutput("stream_count", q_sat.size(), 3);
    checkResult("stream_a", q_sat, 0, 10, 0, sa + 5);
    checkResult("stream_b", q_sat, 1, 3, 0, sb + 5);
    checkResult("stream_c", q_sat, 2, 10, 0, sc + 5);
    if (q_sat.size() >= 2) checkOutput("stream_spacing", q_sat[1].c - q_sat[0].c, 3);

    $display("[TB] flush");
    clearQ();
    applyStimulus(8'sd2, 8'sd5, 8'd10, tmp);
    applyStimulus(8'sd3, 8'sd6, 8'd0, tmp);
    idle(1);
    @(negedge clk);
    a        = 8'sd50;
    b        = 8'sd50;
    x        = 8'd99;
    valid_in = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_busy", int'(bus_sat.busy), 0);
    checkOutput("flush_busy_long", int'(bus_long.busy), 0);
    checkOutput("flush_f_hold", int'(bus_sat.f), 10);
    idle(10);
    checkOutput("flush_no_result", q_sat.size(), 0);
    checkOutput("flush_no_result_long", q_long.size(), 0);
    runBasic(1'b0, s0, s1, s2);
    idle(12);
    checkOutput("flush_after_count", q_sat.size(), 1);
    checkResult("flush_after", q_sat, 0, 10, 0, s2 + 5);
    checkResult("flush_after_long", q_long, 0, 20, 0, s0 + 7);

    $display("[TB] reset mid-vector");
    clearQ();
    applyStimulus(-8'sd128, -8'sd128, 8'd0, tmp);
    applyStimulus(-8'sd128, -8'sd128, 8'd0, tmp);
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    checkOutput("mrst_f", int'(bus_sat.f), 0);
    checkOutput("mrst_valid", int'(bus_sat.valid_out), 0);
    checkOutput("mrst_ovf", int'(bus_sat.overflow), 0);
    checkOutput("mrst_busy", int'(bus_sat.busy), 0);
    reset = 1'b0;
    runBasic(1'b0, s0, s1, s2);
    idle(12);
    checkOutput("mrst_count", q_sat.size(), 1);
    checkResult("mrst_after", q_sat, 0, 10, 0, s2 + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
